// File: rtl/uob_rx_if.sv
// uob_rx_if: handshake bundle for the unit output buffer receiver.
//   Unit side   : uob_dout, uob_empty (to receiver), uob_rd_en (from receiver)
//   Arbiter side: dout, dout_last, empty, err (from receiver), rd_en (to receiver)
// The receiver takes the slave modport; whoever drives the unit stream and
// consumes the reassembled words takes the master modport.
`ifndef UNIT_OUTPUT_WIDTH
`define UNIT_OUTPUT_WIDTH 8
`endif

interface uob_rx_if #(
  parameter int IN_WIDTH  = `UNIT_OUTPUT_WIDTH,
  parameter int OUT_WIDTH = 16
);
  logic [IN_WIDTH-1:0]  uob_dout;
  logic                 uob_empty;
  logic                 uob_rd_en;
  logic [OUT_WIDTH-1:0] dout;
  logic                 dout_last;
  logic                 empty;
  logic                 rd_en;
  logic                 err;

  modport slave (
    input  uob_dout, uob_empty, rd_en,
    output uob_rd_en, dout, dout_last, empty, err
  );

  modport master (
    output uob_dout, uob_empty, rd_en,
    input  uob_rd_en, dout, dout_last, empty, err
  );
endinterface

// File: rtl/uob_rx.sv
// uob_rx: pulls one packet at a time from a unit output buffer (all-ones header
// followed by PKT_LEN*RATIO narrow words), reassembles LSB-first into
// OUT_WIDTH words in a 2-slot packet buffer and presents them as a
// first-word-fall-through stream with a last-word flag.
// Ports:
//   clk  : single clock
//   rst  : synchronous reset, active-high
//   bus  : uob_rx_if.slave (unit stream in, reassembled stream out, sticky err)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_FLUSH  | ignore uob_dout for PKT_LEN*RATIO+3 cycles (drain a burst)
// S_IDLE   | wait for a ready packet and a free slot
// S_REQ    | uob_rd_en high for this single cycle
// S_HDR    | header word on uob_dout, must be all-ones
// S_DATA   | shift in narrow words, write a slot word every RATIO words
// S_COMMIT | mark slot full, move to the other slot
`ifndef UNIT_OUTPUT_WIDTH
`define UNIT_OUTPUT_WIDTH 8
`endif

module uob_rx #(
  parameter int IN_WIDTH  = `UNIT_OUTPUT_WIDTH,
  parameter int OUT_WIDTH = 16,
  parameter int RATIO     = OUT_WIDTH / IN_WIDTH,
  parameter int PKT_LEN   = 20
) (
  input logic    clk,
  input logic    rst,
  uob_rx_if.slave bus
);
  localparam int FLUSH_CYC = PKT_LEN * RATIO + 3;
  localparam int WW        = $clog2(PKT_LEN);
  localparam int SW        = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int FW        = $clog2(FLUSH_CYC);
  localparam int PW        = OUT_WIDTH - IN_WIDTH;

  localparam logic [WW-1:0] LAST_W     = WW'(PKT_LEN - 1);
  localparam logic [SW-1:0] LAST_S     = SW'(RATIO - 1);
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYC - 1);

  typedef enum logic [2:0] {
    S_FLUSH, S_IDLE, S_REQ, S_HDR, S_DATA, S_COMMIT
  } state_e;

  state_e               state_q;
  logic [FW-1:0]        flush_cnt_q;
  logic [SW-1:0]        sub_q;
  logic [WW-1:0]        word_cnt_q;
  logic [WW-1:0]        rd_ptr_q;
  logic [PW-1:0]        part_q;      // upper part of the word being assembled
  logic [1:0]           full_q;
  logic                 wr_slot_q;
  logic                 rd_slot_q;
  logic                 uob_rd_en_q;
  logic                 err_q;
  logic [OUT_WIDTH-1:0] mem_q [2][PKT_LEN];

  logic [OUT_WIDTH-1:0] asm_d;
  logic                 empty_d;
  logic                 pop_d;
  logic                 free_d;
  logic                 slot_avail_d;
  logic                 word_we_d;

  // Newest narrow word enters at the top, so the first word of a group ends
  // up in the low bits once RATIO words have been shifted in.
  assign asm_d   = {bus.uob_dout, part_q};
  assign empty_d = ~full_q[rd_slot_q];
  assign pop_d   = bus.rd_en & ~empty_d;
  assign free_d  = pop_d & (rd_ptr_q == LAST_W);
  // A slot being freed this cycle counts as free so the next request can
  // go out in the very next cycle.
  assign slot_avail_d = ~full_q[wr_slot_q] | (free_d & (rd_slot_q == wr_slot_q));
  assign word_we_d    = (state_q == S_DATA) && (sub_q == LAST_S);

  assign bus.uob_rd_en = uob_rd_en_q;
  assign bus.empty     = empty_d;
  assign bus.dout      = empty_d ? '0 : mem_q[rd_slot_q][rd_ptr_q];
  assign bus.dout_last = ~empty_d & (rd_ptr_q == LAST_W);
  assign bus.err       = err_q;

  always_ff @(posedge clk) begin
    if (word_we_d) mem_q[wr_slot_q][word_cnt_q] <= asm_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FLUSH;
      flush_cnt_q <= FLUSH_LOAD;
      sub_q       <= '0;
      word_cnt_q  <= '0;
      rd_ptr_q    <= '0;
      part_q      <= '0;
      full_q      <= '0;
      wr_slot_q   <= 1'b0;
      rd_slot_q   <= 1'b0;
      uob_rd_en_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      uob_rd_en_q <= 1'b0;

      if (pop_d) begin
        if (free_d) begin
          full_q[rd_slot_q] <= 1'b0;
          rd_slot_q         <= ~rd_slot_q;
          rd_ptr_q          <= '0;
        end else begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
      end

      case (state_q)
        S_FLUSH: begin
          if (flush_cnt_q == '0) state_q <= S_IDLE;
          else                   flush_cnt_q <= flush_cnt_q - 1'b1;
        end
        S_IDLE: begin
          if (~bus.uob_empty && slot_avail_d) begin
            uob_rd_en_q <= 1'b1;
            state_q     <= S_REQ;
          end
        end
        S_REQ: state_q <= S_HDR;
        S_HDR: begin
          if (&bus.uob_dout) begin
            state_q <= S_DATA;
          end else begin
            err_q       <= 1'b1;
            flush_cnt_q <= FLUSH_LOAD;
            state_q     <= S_FLUSH;
          end
        end
        S_DATA: begin
          part_q <= asm_d[OUT_WIDTH-1:IN_WIDTH];
          if (sub_q == LAST_S) begin
            sub_q      <= '0;
            word_cnt_q <= word_cnt_q + 1'b1;
            if (word_cnt_q == LAST_W) state_q <= S_COMMIT;
          end else begin
            sub_q <= sub_q + 1'b1;
          end
        end
        S_COMMIT: begin
          full_q[wr_slot_q] <= 1'b1;
          wr_slot_q         <= ~wr_slot_q;
          word_cnt_q        <= '0;
          sub_q             <= '0;
          state_q           <= S_IDLE;
        end
        default: state_q <= S_FLUSH;
      endcase
    end
  end
endmodule

// File: tb/tb_uob_rx.sv
module tb_uob_rx;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uob_rx_if #(.IN_WIDTH(8), .OUT_WIDTH(16)) bus ();
  uob_rx #(.IN_WIDTH(8), .OUT_WIDTH(16), .RATIO(2), .PKT_LEN(20)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int req_cnt = 0;
  int bad_req = 0;
  logic [7:0]  q_hdr[$];
  logic [7:0]  q_base[$];
  logic [15:0] got_w[20];
  logic        got_l[20];
  bit          got_to[20];

  // Unit-side model: on a request, header next cycle, then 40 bytes base+i,
  // uob_empty held high until 2 cycles after the burst. Not affected by rst.
  initial begin : unit_model
    logic [7:0] h, b;
    bus.uob_dout  = '0;
    bus.uob_empty = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.uob_rd_en) begin
        req_cnt++;
        if (q_hdr.size() == 0) begin
          bad_req++;
        end else begin
          h = q_hdr.pop_front();
          b = q_base.pop_front();
          @(posedge clk); #1;
          bus.uob_empty = 1'b1;
          bus.uob_dout  = h;
          for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            bus.uob_dout = b + 8'(i);
          end
          @(posedge clk); #1;
          bus.uob_dout = '0;
          @(posedge clk); #1;
          bus.uob_empty = (q_hdr.size() == 0);
        end
      end else begin
        bus.uob_empty = (q_hdr.size() == 0);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push(input logic [7:0] h, input logic [7:0] b);
    q_hdr.push_back(h);
    q_base.push_back(b);
  endtask

  // Called and returns at posedge+1.
  task automatic pop_word(output logic [15:0] w, output logic l, output bit to);
    to = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (!bus.empty) begin
        to = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    w = bus.dout;
    l = bus.dout_last;
    if (!to) begin
      bus.rd_en = 1'b1;
      @(posedge clk); #1;
      bus.rd_en = 1'b0;
    end
  endtask

  task automatic read_pkt(input int gap);
    for (int k = 0; k < 20; k++) begin
      pop_word(got_w[k], got_l[k], got_to[k]);
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset;
    checks++; if (bus.uob_rd_en !== 1'b0) begin errors++; $display("FAIL reset_uob_rd_en: got %b expected 0", bus.uob_rd_en); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", bus.empty); end
    checks++; if (bus.dout !== 16'h0000) begin errors++; $display("FAIL reset_dout: got %h expected 0000", bus.dout); end
    checks++; if (bus.dout_last !== 1'b0) begin errors++; $display("FAIL reset_dout_last: got %b expected 0", bus.dout_last); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.err); end
  endtask

  task automatic test_rd_while_empty;
    bus.rd_en = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    bus.rd_en = 1'b0;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rd_empty_empty: got %b expected 1", bus.empty); end
    checks++; if (bus.dout !== 16'h0000 || bus.dout_last !== 1'b0) begin errors++; $display("FAIL rd_empty_dout: got %h/%b expected 0000/0", bus.dout, bus.dout_last); end
    checks++; if (req_cnt !== 0) begin errors++; $display("FAIL rd_empty_flush_req: got %0d requests expected 0", req_cnt); end
  endtask

  task automatic test_single_packet;
    logic [7:0] lo;
    push(8'hFF, 8'h00);
    read_pkt(0);
    checks++; if (got_w[0] !== 16'h0100) begin errors++; $display("FAIL single_first: got %h expected 0100", got_w[0]); end
    checks++; if (got_w[19] !== 16'h2726 || got_l[19] !== 1'b1) begin errors++; $display("FAIL single_last: got %h/%b expected 2726/1", got_w[19], got_l[19]); end
    for (int k = 0; k < 20; k++) begin
      lo = 8'(2 * k);
      checks++;
      if (got_to[k] || got_w[k] !== {lo + 8'd1, lo} || got_l[k] !== (k == 19)) begin
        errors++;
        $display("FAIL single_word%0d: got %h last %b timeout %b, expected %h last %b", k, got_w[k], got_l[k], got_to[k], {lo + 8'd1, lo}, k == 19);
      end
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL single_empty_after: got %b expected 1", bus.empty); end
  endtask

  task automatic test_back_to_back;
    int r0;
    logic [15:0] w;
    logic l;
    bit to;
    logic [7:0] lo;
    logic [7:0] bases[3];
    bases = '{8'h40, 8'h80, 8'hC0};
    r0 = req_cnt;
    push(8'hFF, 8'h40); push(8'hFF, 8'h80); push(8'hFF, 8'hC0);
    repeat (130) begin @(posedge clk); #1; end
    checks++; if (req_cnt - r0 !== 2) begin errors++; $display("FAIL b2b_two_bursts: got %0d requests expected 2", req_cnt - r0); end
    checks++; if (q_hdr.size() !== 1) begin errors++; $display("FAIL b2b_third_waits: got %0d queued expected 1", q_hdr.size()); end
    pop_word(w, l, to);
    checks++; if (to || w !== 16'h4140 || l !== 1'b0) begin errors++; $display("FAIL b2b_first_word: got %h/%b timeout %b expected 4140/0", w, l, to); end
    repeat (5) begin @(posedge clk); #1; end
    checks++; if (req_cnt - r0 !== 2) begin errors++; $display("FAIL b2b_no_req_after_first: got %0d requests expected 2", req_cnt - r0); end
    for (int k = 1; k < 20; k++) pop_word(got_w[k], got_l[k], got_to[k]);
    checks++; if (bus.uob_rd_en !== 1'b1) begin errors++; $display("FAIL b2b_req_after_free: got %b expected 1", bus.uob_rd_en); end
    got_w[0] = w; got_l[0] = l; got_to[0] = to;
    for (int p = 0; p < 3; p++) begin
      if (p > 0) read_pkt(0);
      for (int k = 0; k < 20; k++) begin
        lo = bases[p] + 8'(2 * k);
        checks++;
        if (got_to[k] || got_w[k] !== {lo + 8'd1, lo} || got_l[k] !== (k == 19)) begin
          errors++;
          $display("FAIL b2b_pkt%0d_word%0d: got %h last %b timeout %b, expected %h last %b", p, k, got_w[k], got_l[k], got_to[k], {lo + 8'd1, lo}, k == 19);
        end
      end
    end
    checks++; if (req_cnt - r0 !== 3) begin errors++; $display("FAIL b2b_total_req: got %0d expected 3", req_cnt - r0); end
  endtask

  task automatic test_bad_header;
    logic [7:0] lo;
    push(8'h7F, 8'h10);
    push(8'hFF, 8'h20);
    repeat (60) begin @(posedge clk); #1; end
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL badhdr_err: got %b expected 1", bus.err); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL badhdr_no_output: got empty %b expected 1", bus.empty); end
    read_pkt(0);
    for (int k = 0; k < 20; k++) begin
      lo = 8'h20 + 8'(2 * k);
      checks++;
      if (got_to[k] || got_w[k] !== {lo + 8'd1, lo} || got_l[k] !== (k == 19)) begin
        errors++;
        $display("FAIL badhdr_recover_word%0d: got %h last %b timeout %b, expected %h last %b", k, got_w[k], got_l[k], got_to[k], {lo + 8'd1, lo}, k == 19);
      end
    end
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL badhdr_err_sticky: got %b expected 1", bus.err); end
  endtask

  task automatic test_reset_mid_burst;
    bit found;
    bit quiet;
    logic [7:0] lo;
    push(8'hFF, 8'h30);
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (bus.uob_rd_en) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++; if (!found) begin errors++; $display("FAIL rstmid_request: got no uob_rd_en expected one"); end
    repeat (12) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    push(8'hFF, 8'h50);
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty: got %b expected 1", bus.empty); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rstmid_err: got %b expected 0", bus.err); end
    checks++; if (bus.dout !== 16'h0000) begin errors++; $display("FAIL rstmid_dout: got %h expected 0000", bus.dout); end
    quiet = 1'b1;
    for (int c = 0; c < 43; c++) begin
      if (bus.uob_rd_en) quiet = 1'b0;
      @(posedge clk); #1;
    end
    checks++; if (!quiet) begin errors++; $display("FAIL rstmid_flush_quiet: got uob_rd_en within 43 cycles expected none"); end
    read_pkt(0);
    for (int k = 0; k < 20; k++) begin
      lo = 8'h50 + 8'(2 * k);
      checks++;
      if (got_to[k] || got_w[k] !== {lo + 8'd1, lo} || got_l[k] !== (k == 19)) begin
        errors++;
        $display("FAIL rstmid_word%0d: got %h last %b timeout %b, expected %h last %b", k, got_w[k], got_l[k], got_to[k], {lo + 8'd1, lo}, k == 19);
      end
    end
  endtask

  task automatic test_drain_toggle;
    logic [7:0] lo;
    logic [7:0] bases[2];
    bit stays_empty;
    bases = '{8'h60, 8'h90};
    push(8'hFF, 8'h60);
    push(8'hFF, 8'h90);
    for (int p = 0; p < 2; p++) begin
      read_pkt(1);
      for (int k = 0; k < 20; k++) begin
        lo = bases[p] + 8'(2 * k);
        checks++;
        if (got_to[k] || got_w[k] !== {lo + 8'd1, lo} || got_l[k] !== (k == 19)) begin
          errors++;
          $display("FAIL toggle_pkt%0d_word%0d: got %h last %b timeout %b, expected %h last %b", p, k, got_w[k], got_l[k], got_to[k], {lo + 8'd1, lo}, k == 19);
        end
      end
    end
    stays_empty = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (!bus.empty) stays_empty = 1'b0;
      @(posedge clk); #1;
    end
    checks++; if (!stays_empty) begin errors++; $display("FAIL toggle_no_extra: got empty=0 after drain expected 1"); end
  endtask

  initial begin : main
    rst = 1'b1;
    bus.rd_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_rd_while_empty();
    test_single_packet();
    test_back_to_back();
    test_bad_header();
    test_reset_mid_burst();
    test_drain_toggle();
    checks++; if (bad_req !== 0) begin errors++; $display("FAIL protocol_req_while_empty: got %0d bad requests expected 0", bad_req); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
